// File: rtl/mdu_div_stall_if.sv
// Issue/result bundle between the execute-stage pipeline and the multi-cycle divider.
// The pipeline side uses the master modport; the divider uses the slave modport.
interface mdu_div_stall_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             annul;
    logic             stall;
    logic             valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, a, b, annul,
        input  stall, valid, quotient, remainder
    );

    modport slave (
        input  start, is_signed, a, b, annul,
        output stall, valid, quotient, remainder
    );
endinterface

// File: rtl/mdu_div_stall.sv
// Radix-2 restoring DIV/DIVU unit that stalls the E/M registers until its result is ready.
// Define MDU_DIV_ZERO_FAST_EN to finish a zero-divisor request straight from IDLE.
//
// state | meaning
// IDLE  | waiting for start; stall follows start & ~annul
// BUSY  | one quotient bit per cycle, pipeline stalled
// DONE  | signed result handed over, valid high, stall released
module mdu_div_stall #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    mdu_div_stall_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             sgn_q_q, sgn_q_d;
    logic             sgn_r_q, sgn_r_d;
    logic             dz_q, dz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             valid_c;

    always_comb begin
        a_neg   = bus.is_signed & bus.a[WIDTH-1];
        b_neg   = bus.is_signed & bus.b[WIDTH-1];
        a_abs   = a_neg ? -bus.a : bus.a;
        b_abs   = b_neg ? -bus.b : bus.b;
        shifted = {rem_q, dvd_q[WIDTH-1]};
        // |shifted - divisor| < 2^WIDTH always holds, so bit WIDTH is a true sign bit
        trial   = shifted - {1'b0, dvs_q};
        q_fix   = dz_q ? '1   : (sgn_q_q ? -dvd_q : dvd_q);
        r_fix   = dz_q ? a_q  : (sgn_r_q ? -rem_q : rem_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        dz_d    = dz_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.annul) begin
                    rem_d   = '0;
                    dvd_d   = a_abs;
                    dvs_d   = b_abs;
                    a_d     = bus.a;
                    sgn_q_d = a_neg ^ b_neg;
                    sgn_r_d = a_neg;
                    dz_d    = (bus.b == '0);
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = BUSY;
`ifdef MDU_DIV_ZERO_FAST_EN
                    if (bus.b == '0) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                if (bus.annul) begin
                    state_d = IDLE;
                end else begin
                    rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                if (!bus.annul) begin
                    quo_d = q_fix;
                    rmd_d = r_fix;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            dz_q    <= dz_d;
        end
    end

    // The result is presented during DONE so the released E/M register captures it that cycle
    assign valid_c       = rst & (state_q == DONE) & ~bus.annul;
    assign bus.valid     = valid_c;
    assign bus.quotient  = valid_c ? q_fix : quo_q;
    assign bus.remainder = valid_c ? r_fix : rmd_q;
    assign bus.stall     = rst & ~bus.annul &
                           (((state_q == IDLE) & bus.start) | (state_q == BUSY));

endmodule

// File: tb/tb_mdu_div_stall.sv
// Self-checking bench for mdu_div_stall: directed and random DIV/DIVU against an arithmetic model.
// Build with MDU_DIV_ZERO_FAST_EN defined to expect the short zero-divisor latency.
module tb_mdu_div_stall;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    mdu_div_stall_if #(.WIDTH(W)) bus ();

    mdu_div_stall #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sx, sy;
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = W'(sx / sy);
            r  = W'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns at the same point of the cycle after the hold check.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
        logic [W-1:0] eq, er;
        int exp_lat, lat;
        bit stall_bad;
        model(ai, bi, si, eq, er);
        exp_lat = W + 1;
`ifdef MDU_DIV_ZERO_FAST_EN
        if (bi == '0) exp_lat = 1;
`endif
        bus.start = 1'b1; bus.a = ai; bus.b = bi; bus.is_signed = si;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++;
            $display("FAIL stall_issue a=%h b=%h got %b want 1", ai, bi, bus.stall);
        end
        next_cycle();
        bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.is_signed = 1'($urandom);
        lat = 0;
        stall_bad = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) lat = k;
            else begin
                if (bus.stall !== 1'b1) stall_bad = 1;
                next_cycle();
            end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency a=%h b=%h s=%b got %0d want %0d (0 = timeout)", ai, bi, si, lat, exp_lat);
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL stall_busy a=%h b=%h got low-before-valid want high", ai, bi);
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_done a=%h b=%h got %b want 0", ai, bi, bus.stall);
        end
        checks++;
        if (bus.quotient !== eq || bus.remainder !== er) begin
            errors++;
            $display("FAIL result a=%h b=%h s=%b got q=%h r=%h want q=%h r=%h",
                     ai, bi, si, bus.quotient, bus.remainder, eq, er);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus.valid !== 1'b0 || bus.quotient !== eq || bus.remainder !== er) begin
            errors++;
            $display("FAIL hold a=%h b=%h got v=%b q=%h r=%h want v=0 q=%h r=%h",
                     ai, bi, bus.valid, bus.quotient, bus.remainder, eq, er);
        end
        last_q = eq;
        last_r = er;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd1; bus.is_signed = 1'b0; bus.annul = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.valid !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0) begin
            errors++;
            $display("FAIL reset_state got st=%b v=%b q=%h r=%h want all 0",
                     bus.stall, bus.valid, bus.quotient, bus.remainder);
        end
        bus.start = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_directed();
        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b0);
        run_op(32'h8765_4321, 32'd0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 32'($urandom_range(0, 1000));
                1: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom));
        end
    endtask

    task automatic test_annul();
        logic [W-1:0] pq, pr;
        bit bad;
        pq = last_q;
        pr = last_r;
        bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7; bus.is_signed = 1'b0;
        next_cycle();
        bus.start = 1'b0;
        repeat (9) next_cycle();
        bus.annul = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL annul_busy got st=%b v=%b want 0 0", bus.stall, bus.valid);
        end
        next_cycle();
        bus.annul = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid !== 1'b0 || bus.stall !== 1'b0 || bus.quotient !== pq || bus.remainder !== pr)
                bad = 1;
            next_cycle();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL annul_after got q=%h r=%h want no valid, q=%h r=%h", bus.quotient, bus.remainder, pq, pr);
        end
        bus.start = 1'b1; bus.annul = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL annul_issue got st=%b want 0", bus.stall);
        end
        next_cycle();
        bus.start = 1'b0; bus.annul = 1'b0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.valid !== 1'b0 || bus.stall !== 1'b0) bad = 1;
            next_cycle();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL annul_idle got activity want stays IDLE");
        end
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1; bus.a = 32'd50000; bus.b = 32'd13; bus.is_signed = 1'b0;
        next_cycle();
        bus.start = 1'b0;
        repeat (4) next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.valid !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0) begin
            errors++;
            $display("FAIL reset_mid got st=%b v=%b q=%h r=%h want all 0",
                     bus.stall, bus.valid, bus.quotient, bus.remainder);
        end
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
        run_op(32'd9, 32'd3, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op(32'hDEAD_BEEF, 32'd16, 1'b0);
        run_op(32'hDEAD_BEEF, 32'hFFFF_FFF0, 1'b1);
        run_op(32'd0, 32'd5, 1'b1);
    endtask

    initial begin
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.a = '0; bus.b = '0; bus.annul = 1'b0;
        test_reset();
        test_directed();
        test_annul();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_div_stall.md
Name: mdu_div_stall

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage, issued by MIPS DIV/DIVU.
- Drives the stall signal that gates the enable inputs of the E/M pipeline registers, and captures the flush that clears them.
- Results go to the HI/LO write path: quotient to LO, remainder to HI.
- Stalls the pipeline from issue until the result is ready, then releases it for exactly one cycle to hand the result over.

Parameters:
- WIDTH, 32, operand/result width in bits; any value ≥ 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low; all state clears while rst=0.
- start  in  1  issue request; sampled only in IDLE.
- is_signed  in  1  1=DIV (two's complement), 0=DIVU; captured with start.
- a  in  WIDTH  dividend; captured with start.
- b  in  WIDTH  divisor; captured with start.
- annul  in  1  pipeline flush; cancels any operation in flight.
- stall  out  1  combinational: (state==IDLE & start & ~annul) | state==BUSY.
- valid  out  1  one-cycle pulse; result registers updated.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; counter=0; valid=0; quotient=0; remainder=0; internal operand registers=0.
- States: IDLE, BUSY, DONE. Two-bit encoding; unused code returns to IDLE.
- IDLE:
  - start=1 & annul=0: latch |a| and |b| (absolute values if is_signed, else raw).
  - Also latch sign_q = a[W-1]^b[W-1], sign_r = a[W-1] (both forced 0 when unsigned) and a zero-divisor flag.
  - Load counter=WIDTH; go to BUSY.
- BUSY, one iteration per cycle:
  - Shift {partial remainder, dividend} left 1.
  - trial = partial remainder − |b| using a WIDTH+1-bit subtract.
  - If trial is non-negative: take trial and set quotient bit=1; else keep the remainder and set the bit to 0.
  - Decrement counter. When it reaches 1 in this cycle, go to DONE.
- DONE (one cycle):
  - Apply sign fixup: negate q if sign_q; negate r if sign_r.
  - Register both outputs; valid=1; stall=0; go to IDLE.
- Latency: start in cycle 0 → valid in cycle WIDTH+1. stall is high in cycles 0..WIDTH and low in DONE, so the downstream enabled register captures the result in that cycle.
- Outputs hold their last value until the next DONE; valid is never high for two consecutive cycles.
- start while BUSY/DONE: ignored. The upstream stall guarantees it is not reissued.
- annul has priority over start and over progress in every state:
  - Next state is IDLE, with no valid and no output update.
  - stall drops in the same cycle annul is asserted.
- Divide by zero (b==0), signedness-independent: quotient=all ones, remainder=a (original value). Full WIDTH+1 latency unless the optional feature is enabled.
- Overflow (is_signed, a=−2^(W−1), b=−1): quotient=0x8000_0000, remainder=0. This falls out of the unsigned magnitude path plus the WIDTH-bit negate; no special case is needed.
- Arithmetic: all negations are two's complement, truncated to WIDTH. The magnitude of −2^(W−1) is represented as unsigned 2^(W−1).
- Reset mid-operation: immediate return to IDLE; stall=0 while rst=0; outputs zero.

Optional Feature:
- Macro: MDU_DIV_ZERO_FAST_EN.
- Defined: start with b==0 (and annul=0) goes from IDLE directly to DONE.
  - Outputs quotient=all ones and remainder=a with valid in cycle 1.
  - stall is high in cycle 0 only.
- Undefined: a zero divisor iterates the full WIDTH cycles, with identical final values and latency WIDTH+1.

Test Plan:
- Unsigned: start, is_signed=0, a=100, b=7 → stall high 33 cycles, then valid pulse in cycle 33 (WIDTH=32) with quotient=14, remainder=2; stall low that cycle.
- Signed: a=0xFFFF_FFF9 (−7), b=2 → quotient=0xFFFF_FFFD (−3), remainder=0xFFFF_FFFF (−1). Then a=7, b=0xFFFF_FFFE → quotient=0xFFFF_FFFD, remainder=1.
- Overflow: is_signed=1, a=0x8000_0000, b=0xFFFF_FFFF → quotient=0x8000_0000, remainder=0.
- Divide by zero, a=0x1234_5678, b=0:
  - quotient=0xFFFF_FFFF, remainder=0x1234_5678.
  - valid in cycle 33 without the macro; in cycle 1 with MDU_DIV_ZERO_FAST_EN.
- Annul: start a=100, b=7; annul in cycle 10 → stall=0 in cycle 10, no valid ever, outputs retain the previous result.
  - Also: start+annul in the same cycle → stall=0, stays IDLE.
- Reset: rst=0 in cycle 5 of BUSY → stall, valid, quotient and remainder all 0 immediately.
  - After release, a new start a=9, b=3 → quotient=3, remainder=0.
